mem_access_ctrl: RTL and testbench

Bus initiator for the shared 16-bit program/data memory. It takes instruction-fetch requests and load/store requests from the CPU core and arbitrates between them. It sequences the memory's strobes (d_read, d_write, d_push, i_read, i_push), drives the address ports, owns the tristate d_bus during stores, and returns read data to the requester with a one-cycle ack pulse. It sits between the CPU datapath and the memory block.

---
 rtl/mem_access_ctrl_if.sv | 38 +++
 rtl/mem_access_ctrl.sv | 105 ++++++++++
 tb/tb_mem_access_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/ack handshakes and memory strobe/address lines of the memory access controller.
// d_bus is bidirectional and is carried as a separate port on the controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic [DATA_W-1:0] fetch_data;
    logic              ld_req;
    logic              st_req;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] st_data;
    logic              ls_ack;
    logic [DATA_W-1:0] ld_data;
    logic              addr_err;
    logic              busy;
    logic              d_read;
    logic              d_write;
    logic              d_push;
    logic              i_read;
    logic              i_push;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] i_addr;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, st_req, ls_addr, st_data,
        output fetch_ack, fetch_data, ls_ack, ld_data, addr_err, busy,
        output d_read, d_write, d_push, i_read, i_push, d_addr, i_addr
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, st_req, ls_addr, st_data,
        input  fetch_ack, fetch_data, ls_ack, ld_data, addr_err, busy,
        input  d_read, d_write, d_push, i_read, i_push, d_addr, i_addr
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Bus initiator for the shared program/data memory: round-robin arbitration between
// instruction fetches and loads/stores, strobe sequencing, and read-data return.
module mem_access_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MEM_SIZE = 512
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus,
    inout  wire  [DATA_W-1:0] d_bus
);
    typedef enum logic [2:0] {IDLE, LD_RD, LD_PUSH, ST_WR, IF_RD, IF_PUSH} state_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_SIZE);

    state_t            state, state_nxt;
    logic              last_data;
    logic              oor_q;
    logic [ADDR_W-1:0] d_addr_q, i_addr_q;
    logic [DATA_W-1:0] st_data_q, fetch_data_q, ld_data_q;
    logic              fetch_ack_q, ls_ack_q, addr_err_q;
    logic              data_elig, fetch_elig, grant_data, grant_fetch;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= LIMIT;
    endfunction

    // A requester whose ack is visible this cycle is still holding its request; ignore it.
    always_comb begin
        data_elig   = (bus.ld_req | bus.st_req) & ~ls_ack_q;
        fetch_elig  = bus.fetch_req & ~fetch_ack_q;
        grant_data  = data_elig & (~fetch_elig | ~last_data);
        grant_fetch = fetch_elig & ~grant_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_data)       state_nxt = bus.st_req ? ST_WR : LD_RD;
                else if (grant_fetch) state_nxt = IF_RD;
            end
            LD_RD:   state_nxt = LD_PUSH;
            IF_RD:   state_nxt = IF_PUSH;
            LD_PUSH: state_nxt = IDLE;
            IF_PUSH: state_nxt = IDLE;
            ST_WR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_data    <= 1'b0;
            oor_q        <= 1'b0;
            d_addr_q     <= '0;
            i_addr_q     <= '0;
            st_data_q    <= '0;
            fetch_data_q <= '0;
            ld_data_q    <= '0;
            fetch_ack_q  <= 1'b0;
            ls_ack_q     <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            if (state == IDLE && grant_data) begin
                d_addr_q  <= bus.ls_addr;
                st_data_q <= bus.st_data;
                oor_q     <= out_of_range(bus.ls_addr);
                last_data <= 1'b1;
            end else if (state == IDLE && grant_fetch) begin
                i_addr_q  <= bus.fetch_addr;
                oor_q     <= out_of_range(bus.fetch_addr);
                last_data <= 1'b0;
            end
            // Memory result is on d_bus during the push cycle; out-of-range reads return zero.
            if (state == LD_PUSH) ld_data_q    <= oor_q ? '0 : d_bus;
            if (state == IF_PUSH) fetch_data_q <= oor_q ? '0 : d_bus;
            ls_ack_q    <= (state == LD_PUSH) || (state == ST_WR);
            fetch_ack_q <= (state == IF_PUSH);
            addr_err_q  <= ((state == LD_PUSH) || (state == ST_WR) || (state == IF_PUSH)) && oor_q;
        end
    end

    assign bus.d_read     = (state == LD_RD)   && !oor_q;
    assign bus.d_push     = (state == LD_PUSH) && !oor_q;
    assign bus.d_write    = (state == ST_WR)   && !oor_q;
    assign bus.i_read     = (state == IF_RD)   && !oor_q;
    assign bus.i_push     = (state == IF_PUSH) && !oor_q;
    assign bus.d_addr     = d_addr_q;
    assign bus.i_addr     = i_addr_q;
    assign bus.fetch_ack  = fetch_ack_q;
    assign bus.fetch_data = fetch_data_q;
    assign bus.ls_ack     = ls_ack_q;
    assign bus.ld_data    = ld_data_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.busy       = (state != IDLE);

    assign d_bus = bus.d_write ? st_data_q : 'z;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed vector table, contention/reset sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_access_ctrl;
    localparam int KF = 0, KL = 1, KS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    wire [15:0] d_bus;

    mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_SIZE(512)) dut (
        .clk(clk), .rst(rst), .bus(bus), .d_bus(d_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        if (i == 16) return 16'hBF01;
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // Memory model: one cycle read latency, drives d_bus only during push cycles.
    logic [15:0] mem [0:511];
    logic [15:0] rd_d, rd_i;
    bit mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            if (bus.d_read)  rd_d <= mem[bus.d_addr[8:0]];
            if (bus.i_read)  rd_i <= mem[bus.i_addr[8:0]];
            if (bus.d_write) mem[bus.d_addr[8:0]] <= d_bus;
        end
    end
    assign d_bus = bus.d_push ? rd_d : (bus.i_push ? rd_i : 16'bz);

    // Bus invariants every cycle.
    always @(negedge clk) begin
        chk("strobe_onehot",
            ($countones({bus.d_read, bus.d_write, bus.d_push, bus.i_read, bus.i_push}) <= 1), 1);
        if (!bus.d_write && !bus.d_push && !bus.i_push)
            chk("dbus_released", ((d_bus === 16'h0) || (d_bus === 16'bz)), 1);
    end

    // Transaction-level reference model, active during the random phase.
    bit model_on, model_synced;
    logic [15:0] shadow [0:511];
    int m_phase, m_kind;
    logic [15:0] m_addr, m_wdata;
    bit m_oor, m_last_data;
    logic e_fack, e_lsack, e_err;
    logic [15:0] e_fdata, e_ldata;

    always @(negedge clk) begin
        if (model_on) begin
            logic nf, nl, ne;
            logic [15:0] val;
            bit dreq, freq, take_data;
            if (!model_synced) begin
                shadow = mem;
                m_phase = 0; m_kind = KF; m_addr = 0; m_wdata = 0; m_oor = 0; m_last_data = 0;
                e_fack = 0; e_lsack = 0; e_err = 0; e_fdata = 0; e_ldata = 0;
                model_synced = 1;
            end
            chk("m_busy", bus.busy, (m_phase != 0));
            chk("m_fetch_ack", bus.fetch_ack, e_fack);
            chk("m_ls_ack", bus.ls_ack, e_lsack);
            chk("m_addr_err", bus.addr_err, e_err);
            chk("m_fetch_data", bus.fetch_data, e_fdata);
            chk("m_ld_data", bus.ld_data, e_ldata);
            chk("m_strobes", {bus.d_read, bus.d_push, bus.d_write, bus.i_read, bus.i_push},
                {m_phase == 1 && m_kind == KL && !m_oor, m_phase == 2 && m_kind == KL && !m_oor,
                 m_phase == 1 && m_kind == KS && !m_oor, m_phase == 1 && m_kind == KF && !m_oor,
                 m_phase == 2 && m_kind == KF && !m_oor});
            if (m_phase != 0 && !m_oor && m_kind != KF) chk("m_d_addr", bus.d_addr, m_addr);
            if (m_phase != 0 && !m_oor && m_kind == KF) chk("m_i_addr", bus.i_addr, m_addr);
            if (m_phase == 1 && m_kind == KS && !m_oor) chk("m_st_bus", d_bus, m_wdata);

            nf = 0; nl = 0; ne = 0;
            if (m_phase == 1 && m_kind == KS) begin
                if (!m_oor) shadow[m_addr[8:0]] = m_wdata;
                nl = 1; ne = m_oor; m_phase = 0;
            end else if (m_phase == 2) begin
                val = m_oor ? 16'h0 : shadow[m_addr[8:0]];
                if (m_kind == KF) begin e_fdata = val; nf = 1; end
                else begin e_ldata = val; nl = 1; end
                ne = m_oor; m_phase = 0;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                dreq = (bus.ld_req || bus.st_req) && !e_lsack;
                freq = bus.fetch_req && !e_fack;
                take_data = dreq && (!freq || !m_last_data);
                if (take_data) begin
                    m_kind = bus.st_req ? KS : KL;
                    m_addr = bus.ls_addr; m_wdata = bus.st_data;
                    m_oor = (int'(bus.ls_addr) >= 512); m_last_data = 1; m_phase = 1;
                end else if (freq) begin
                    m_kind = KF; m_addr = bus.fetch_addr;
                    m_oor = (int'(bus.fetch_addr) >= 512); m_last_data = 0; m_phase = 1;
                end
            end
            e_fack = nf; e_lsack = nl; e_err = ne;
        end
    end

    task automatic clear_inputs();
        bus.fetch_req = 0; bus.fetch_addr = 0; bus.ld_req = 0; bus.st_req = 0;
        bus.ls_addr = 0; bus.st_data = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Runs one isolated transaction; cycle 0 is the cycle the request is raised.
    task automatic run_txn(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                           output int lat, output int rd_c, output int push_c, output int wr_c,
                           output logic [15:0] bus_seen, output logic err_seen, output int nstb);
        lat = -1; rd_c = -1; push_c = -1; wr_c = -1; bus_seen = 0; err_seen = 0; nstb = 0;
        @(posedge clk); #1;
        if (kind == KF) begin bus.fetch_req = 1; bus.fetch_addr = addr; end
        else begin
            bus.ls_addr = addr; bus.st_data = wdata;
            if (kind == KS) bus.st_req = 1; else bus.ld_req = 1;
        end
        for (int c = 0; c < 12 && lat < 0; c++) begin
            @(negedge clk);
            nstb += $countones({bus.d_read, bus.d_write, bus.d_push, bus.i_read, bus.i_push});
            if ((kind == KF && bus.i_read) || (kind == KL && bus.d_read)) rd_c = c;
            if ((kind == KF && bus.i_push) || (kind == KL && bus.d_push)) begin
                push_c = c; bus_seen = d_bus;
            end
            if (bus.d_write) begin wr_c = c; bus_seen = d_bus; end
            if ((kind == KF && bus.fetch_ack) || (kind != KF && bus.ls_ack)) begin
                lat = c; err_seen = bus.addr_err;
            end
        end
        @(posedge clk); #1;
        bus.fetch_req = 0; bus.ld_req = 0; bus.st_req = 0;
    endtask

    typedef struct {
        int kind; logic [15:0] addr; logic [15:0] wdata;
        int lat; int rd; int push; int wr; logic [15:0] data; logic err; int nstb;
    } vec_t;
    vec_t vt [12];

    function automatic logic [15:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return 16'($urandom_range(512, 65535));
        if (r == 1) return ($urandom_range(0, 1) == 1) ? 16'd511 : 16'd512;
        return 16'($urandom_range(0, 511));
    endfunction

    initial begin
        int lat, rd_c, push_c, wr_c, nstb;
        logic [15:0] bus_seen;
        logic err_seen;
        bit sf, sl;

        vt[0]  = '{KF, 16'd16,    16'h0,    3,  1,  2, -1, 16'hBF01,       1'b0, 2};
        vt[1]  = '{KS, 16'd300,   16'h1234, 2, -1, -1,  1, 16'h1234,       1'b0, 1};
        vt[2]  = '{KL, 16'd300,   16'h0,    3,  1,  2, -1, 16'h1234,       1'b0, 2};
        vt[3]  = '{KL, 16'd600,   16'h0,    3, -1, -1, -1, 16'h0,          1'b1, 0};
        vt[4]  = '{KS, 16'd512,   16'hDEAD, 2, -1, -1, -1, 16'h0,          1'b1, 0};
        vt[5]  = '{KL, 16'd511,   16'h0,    3,  1,  2, -1, init_val(511),  1'b0, 2};
        vt[6]  = '{KF, 16'd512,   16'h0,    3, -1, -1, -1, 16'h0,          1'b1, 0};
        vt[7]  = '{KF, 16'hFFFF,  16'h0,    3, -1, -1, -1, 16'h0,          1'b1, 0};
        vt[8]  = '{KL, 16'd0,     16'h0,    3,  1,  2, -1, init_val(0),    1'b0, 2};
        vt[9]  = '{KS, 16'd0,     16'hBEEF, 2, -1, -1,  1, 16'hBEEF,       1'b0, 1};
        vt[10] = '{KF, 16'd0,     16'h0,    3,  1,  2, -1, 16'hBEEF,       1'b0, 2};
        vt[11] = '{KL, 16'hFFFF,  16'h0,    3, -1, -1, -1, 16'h0,          1'b1, 0};

        clear_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_outputs",
            {bus.fetch_ack, bus.ls_ack, bus.addr_err, bus.busy, bus.d_read, bus.d_write,
             bus.d_push, bus.i_read, bus.i_push}, 0);
        chk("rst_addrs", {bus.d_addr, bus.i_addr}, 0);
        chk("rst_data", {bus.fetch_data, bus.ld_data}, 0);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            run_txn(vt[i].kind, vt[i].addr, vt[i].wdata, lat, rd_c, push_c, wr_c,
                    bus_seen, err_seen, nstb);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_rd", i), rd_c, vt[i].rd);
            chk($sformatf("v%0d_push", i), push_c, vt[i].push);
            chk($sformatf("v%0d_wr", i), wr_c, vt[i].wr);
            chk($sformatf("v%0d_nstb", i), nstb, vt[i].nstb);
            chk($sformatf("v%0d_err", i), err_seen, vt[i].err);
            if (vt[i].kind == KF) chk($sformatf("v%0d_fdata", i), bus.fetch_data, vt[i].data);
            if (vt[i].kind == KL) chk($sformatf("v%0d_ldata", i), bus.ld_data, vt[i].data);
            if (vt[i].kind == KS && !vt[i].err) chk($sformatf("v%0d_stbus", i), bus_seen, vt[i].data);
            if (vt[i].kind == KF && !vt[i].err) chk($sformatf("v%0d_pushbus", i), bus_seen, vt[i].data);
        end

        // Contention: fetch and load raised together, requesters re-raise after each ack.
        begin
            int order[$];
            int first_ls = -1, first_f = -1;
            reset_dut();
            @(posedge clk); #1;
            bus.fetch_req = 1; bus.fetch_addr = 16; bus.ld_req = 1; bus.ls_addr = 300;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                sl = bus.ls_ack; sf = bus.fetch_ack;
                if (sl) begin
                    order.push_back(0);
                    if (first_ls < 0) first_ls = c;
                    chk("cont_ld_data", bus.ld_data, 16'h1234);
                end
                if (sf) begin
                    order.push_back(1);
                    if (first_f < 0) first_f = c;
                    chk("cont_fetch_data", bus.fetch_data, 16'hBF01);
                end
                @(posedge clk); #1;
                if (sl) bus.ld_req = 0; else if (!bus.ld_req) bus.ld_req = 1;
                if (sf) bus.fetch_req = 0; else if (!bus.fetch_req) bus.fetch_req = 1;
            end
            clear_inputs();
            chk("cont_first_ls", first_ls, 3);
            chk("cont_first_fetch", first_f, 6);
            chk("cont_ack_count", order.size(), 9);
            for (int k = 0; k < order.size(); k++) chk($sformatf("cont_order%0d", k), order[k], k % 2);
            repeat (4) @(negedge clk);
        end

        // Load and store together: store first, then the pending load.
        begin
            int acks[$];
            int wr_at = -1, rd_at = -1;
            reset_dut();
            @(posedge clk); #1;
            bus.ld_req = 1; bus.st_req = 1; bus.ls_addr = 100; bus.st_data = 16'h7777;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                sl = bus.ls_ack;
                if (bus.d_write) begin wr_at = c; chk("ldst_wbus", d_bus, 16'h7777); end
                if (bus.d_read) rd_at = c;
                if (sl) begin
                    acks.push_back(c);
                    if (acks.size() == 2) chk("ldst_ld_data", bus.ld_data, 16'h7777);
                end
                @(posedge clk); #1;
                if (sl) begin if (bus.st_req) bus.st_req = 0; else bus.ld_req = 0; end
            end
            clear_inputs();
            chk("ldst_wr_cycle", wr_at, 1);
            chk("ldst_rd_cycle", rd_at, 4);
            chk("ldst_ack_count", acks.size(), 2);
            if (acks.size() == 2) begin
                chk("ldst_ack0", acks[0], 2);
                chk("ldst_ack1", acks[1], 6);
            end
        end

        // Reset asserted during the push cycle of a load.
        begin
            bit seen_push = 0;
            lat = -1;
            reset_dut();
            @(posedge clk); #1;
            bus.ld_req = 1; bus.ls_addr = 300;
            for (int c = 0; c < 8 && !seen_push; c++) begin
                @(negedge clk);
                if (bus.d_push) seen_push = 1;
            end
            chk("rmid_reached_push", seen_push, 1);
            #2 rst = 1;
            #1;
            chk("rmid_outputs", {bus.d_push, bus.busy, bus.ls_ack, bus.addr_err, bus.d_read}, 0);
            chk("rmid_ld_data", bus.ld_data, 0);
            @(negedge clk);
            chk("rmid_no_ack", bus.ls_ack, 0);
            rst = 0;
            for (int c = 1; c < 10 && lat < 0; c++) begin
                @(negedge clk);
                if (bus.ls_ack) lat = c;
            end
            chk("rmid_reissue_lat", lat, 3);
            chk("rmid_reissue_data", bus.ld_data, 16'h1234);
            @(posedge clk); #1;
            clear_inputs();
        end

        // Randomized traffic against the reference model.
        reset_dut();
        @(posedge clk); #1;
        model_on = 1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            sf = bus.fetch_ack; sl = bus.ls_ack;
            @(posedge clk); #1;
            if (sf) bus.fetch_req = 0;
            else if (!bus.fetch_req && $urandom_range(0, 3) == 0) begin
                bus.fetch_req = 1; bus.fetch_addr = rand_addr();
            end
            if (sl) begin
                if (bus.st_req) bus.st_req = 0; else bus.ld_req = 0;
            end else if (!bus.ld_req && !bus.st_req && $urandom_range(0, 2) == 0) begin
                int r = $urandom_range(0, 5);
                bus.ls_addr = rand_addr();
                bus.st_data = 16'($urandom);
                bus.ld_req = (r != 0 && r <= 3) || r == 5;
                bus.st_req = (r == 0) || (r == 4) || (r == 5);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
